// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind the SPI slave: parses framed command bytes, streams pixels
// into the frame buffer, holds config registers, drives show_req and the status byte.
module spi_cmd_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_LEDS   = 512,
  parameter int NUM_CFG    = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  input  logic                   rx_timeout,
  output logic [7:0]             tx_byte,
  output logic                   fb_we,
  output logic [ADDR_WIDTH-1:0]  fb_addr,
  output logic [23:0]            fb_data,
  output logic [8*NUM_CFG-1:0]   cfg_regs,
  output logic                   show_req,
  input  logic                   show_ack,
  output logic                   err,
  output logic [3:0]             state_dbg
);

  // One extra counter bit so the pixel counter can rest at NUM_LEDS even when
  // NUM_LEDS equals the full address space.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LED_LIMIT = CNT_W'(NUM_LEDS);
  localparam logic [8:0]       CFG_LIMIT = 9'(NUM_CFG);

  typedef enum logic [3:0] {
    S_CMD     = 4'd0,
    S_ADDR_HI = 4'd1,
    S_ADDR_LO = 4'd2,
    S_PIX_R   = 4'd3,
    S_PIX_G   = 4'd4,
    S_PIX_B   = 4'd5,
    S_CFG_IDX = 4'd6,
    S_CFG_VAL = 4'd7,
    S_DISCARD = 4'd8
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LED_LIMIT) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] status_byte(input logic e, input logic s, input logic busy);
    return {4'b0000, e, s, busy, 1'b1};
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             r_q, r_d;
  logic [7:0]             g_q, g_d;
  logic [7:0]             idx_q, idx_d;
  logic [7:0]             tx_q, tx_d;
  logic                   fb_we_q, fb_we_d;
  logic [ADDR_WIDTH-1:0]  fb_addr_q, fb_addr_d;
  logic [23:0]            fb_data_q, fb_data_d;
  logic [8*NUM_CFG-1:0]   cfg_q, cfg_d;
  logic                   show_q, show_d;
  logic                   err_q, err_d;
  logic                   err_set, err_clr, show_cmd;
  logic [15:0]            addr_full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    r_d       = r_q;
    g_d       = g_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    cfg_d     = cfg_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    show_cmd  = 1'b0;
    addr_full = {hi_q, rx_byte};

    // A timeout ends the transaction and drops any byte arriving with it.
    if (rx_timeout) begin
      state_d = S_CMD;
    end else if (rx_valid) begin
      case (state_q)
        S_CMD: begin
          case (rx_byte)
            8'h01: state_d = S_ADDR_HI;
            8'h02: state_d = S_CFG_IDX;
            8'h03: begin
              tx_d    = status_byte(err_q, show_q, state_q != S_CMD);
              err_clr = 1'b1;
            end
            8'h04: show_cmd = 1'b1;
            default: begin
              err_set = 1'b1;
              state_d = S_DISCARD;
            end
          endcase
        end
        S_ADDR_HI: begin
          hi_d    = rx_byte;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          cnt_d   = CNT_W'(addr_full[ADDR_WIDTH-1:0]);
          state_d = S_PIX_R;
        end
        S_PIX_R: begin
          r_d     = rx_byte;
          state_d = S_PIX_G;
        end
        S_PIX_G: begin
          g_d     = rx_byte;
          state_d = S_PIX_B;
        end
        S_PIX_B: begin
          if (cnt_q < LED_LIMIT) begin
            fb_we_d   = 1'b1;
            fb_addr_d = cnt_q[ADDR_WIDTH-1:0];
            fb_data_d = {g_q, r_q, rx_byte};
          end else begin
            err_set = 1'b1;
          end
          cnt_d   = sat_inc(cnt_q);
          state_d = S_PIX_R;
        end
        S_CFG_IDX: begin
          idx_d   = rx_byte;
          state_d = S_CFG_VAL;
        end
        S_CFG_VAL: begin
          if ({1'b0, idx_q} < CFG_LIMIT) begin
            for (int i = 0; i < NUM_CFG; i++) begin
              if (idx_q == 8'(i)) cfg_d[8*i +: 8] = rx_byte;
            end
          end else begin
            err_set = 1'b1;
          end
          state_d = S_CMD;
        end
        S_DISCARD: state_d = S_DISCARD;
        default:   state_d = S_CMD;
      endcase
    end

    // Acknowledge wins over a merged SHOW; a set beats a clear on err.
    if (show_q && show_ack) show_d = 1'b0;
    else if (show_cmd)      show_d = 1'b1;
    else                    show_d = show_q;

    err_d = (err_q && !err_clr) || err_set;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_CMD;
      cnt_q     <= '0;
      hi_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      cfg_q     <= '0;
      show_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      r_q       <= r_d;
      g_q       <= g_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      cfg_q     <= cfg_d;
      show_q    <= show_d;
      err_q     <= err_d;
    end
  end

  assign tx_byte   = tx_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign cfg_regs  = cfg_q;
  assign show_req  = show_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: a byte-level command model predicts frame-buffer
// writes, status bytes and register state; a negedge monitor compares the DUT.
module tb_spi_cmd_ctrl;

  localparam int AW = 10;
  localparam int NL = 512;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic            rx_valid = 1'b0;
  logic            rx_timeout = 1'b0;
  logic            show_ack = 1'b0;
  logic [7:0]      tx_byte;
  logic            fb_we;
  logic [AW-1:0]   fb_addr;
  logic [23:0]     fb_data;
  logic [8*NC-1:0] cfg_regs;
  logic            show_req;
  logic            err;
  logic [3:0]      state_dbg;

  spi_cmd_ctrl #(.ADDR_WIDTH(AW), .NUM_LEDS(NL), .NUM_CFG(NC)) dut (
    .clk(clk), .resetn(resetn), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_timeout(rx_timeout), .tx_byte(tx_byte), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .cfg_regs(cfg_regs), .show_req(show_req), .show_ack(show_ack),
    .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [23:0] data;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         fbq[$];
  logic [7:0]  txq[$];
  logic [7:0]  cq[$];
  int          m_addr = 0;
  bit          m_err = 1'b0;
  bit          m_show = 1'b0;
  logic [8*NC-1:0] m_cfg = '0;
  bit          mon_en = 1'b0;
  bit          prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    fbq.delete();
    txq.delete();
    m_addr = 0;
    m_err  = 1'b0;
    m_show = 1'b0;
    m_cfg  = '0;
  endtask

  // cq holds the bytes of the command in progress; a completed pixel triple is
  // consumed so that cq keeps {cmd, hi, lo} while streaming.
  task automatic model_byte(input logic [7:0] b);
    int idx;
    cq.push_back(b);
    case (cq[0])
      8'h01: begin
        if (cq.size() == 3) begin
          m_addr = int'({cq[1], cq[2]}) % (1 << AW);
        end else if (cq.size() == 6) begin
          if (m_addr < NL) begin
            fbq.push_back('{m_addr, {cq[4], cq[3], cq[5]}});
            m_addr = m_addr + 1;
          end else begin
            m_err = 1'b1;
          end
          repeat (3) cq.delete(cq.size() - 1);
        end
      end
      8'h02: begin
        if (cq.size() == 3) begin
          idx = int'(cq[1]);
          if (idx < NC) m_cfg[8*idx +: 8] = cq[2];
          else          m_err = 1'b1;
          cq.delete();
        end
      end
      8'h03: begin
        txq.push_back({4'b0000, m_err, m_show, 1'b0, 1'b1});
        m_err = 1'b0;
        cq.delete();
      end
      8'h04: begin
        m_show = 1'b1;
        cq.delete();
      end
      default: begin
        if (cq.size() == 1) m_err = 1'b1;
        else                cq.delete(cq.size() - 1);
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_byte = b; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic timeout_pulse(input bit with_byte, input logic [7:0] b);
    @(posedge clk);
    #1 rx_timeout = 1'b1; rx_valid = with_byte; rx_byte = b;
    @(posedge clk);
    #1 rx_timeout = 1'b0; rx_valid = 1'b0;
    cq.delete();
  endtask

  task automatic ack_pulse();
    @(posedge clk);
    #1 show_ack = 1'b1;
    @(posedge clk);
    #1 show_ack = 1'b0;
    m_show = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_byte"},   64'(tx_byte),   64'd0);
    check({tag, "_fb_we"},     64'(fb_we),     64'd0);
    check({tag, "_fb_addr"},   64'(fb_addr),   64'd0);
    check({tag, "_fb_data"},   64'(fb_data),   64'd0);
    check({tag, "_cfg_regs"},  64'(cfg_regs),  64'd0);
    check({tag, "_show_req"},  64'(show_req),  64'd0);
    check({tag, "_err"},       64'(err),       64'd0);
    check({tag, "_state_dbg"}, 64'(state_dbg), 64'd0);
  endtask

  // Monitor: pops expected writes/status bytes as the DUT presents them and
  // tracks the register-level state every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fb_we) begin
        check("fb_we_gap", 64'(prev_we), 64'd0);
        if (fbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL fb_unexpected: got write addr %0d data %0h expected no write", fb_addr, fb_data);
        end else begin
          wr_t w;
          w = fbq.pop_front();
          check("fb_addr", 64'(fb_addr), 64'(w.addr));
          check("fb_data", 64'(fb_data), 64'(w.data));
        end
      end
      prev_we = fb_we;
      if (txq.size() > 0) check("tx_byte", 64'(tx_byte), 64'(txq.pop_front()));
      check("err",      64'(err),      64'(m_err));
      check("show_req", 64'(show_req), 64'(m_show));
      check("cfg_regs", 64'(cfg_regs), 64'(m_cfg));
      check("state_is_cmd", 64'(state_dbg == 4'd0), 64'(cq.size() == 0));
    end else begin
      prev_we = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hi;
    logic [7:0] cmd;
    int kind;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    mon_en = 1'b1;

    send_seq('{8'h01, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    timeout_pulse(1'b0, 8'h00);

    // Last valid pixel, then one past the end.
    send_seq('{8'h01, 8'h01, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF});
    timeout_pulse(1'b0, 8'h00);
    send_seq('{8'h01, 8'h02, 8'h00, 8'h12, 8'h34, 8'h56});
    timeout_pulse(1'b0, 8'h00);
    send_byte(8'h03);
    idle(2);
    check("status_0x09", 64'(tx_byte), 64'h09);

    send_seq('{8'h02, 8'h01, 8'h5A});
    send_seq('{8'h02, 8'h07, 8'h12});
    idle(1);
    check("cfg1_5a", 64'(cfg_regs[15:8]), 64'h5A);

    send_byte(8'h04);
    idle(10);
    check("show_held", 64'(show_req), 64'd1);
    send_byte(8'h04);
    ack_pulse();
    idle(1);
    check("show_cleared", 64'(show_req), 64'd0);
    ack_pulse();

    send_seq('{8'h01, 8'h00, 8'h00, 8'h11, 8'h22});
    timeout_pulse(1'b0, 8'h00);
    send_byte(8'h04);
    ack_pulse();
    send_seq('{8'h01, 8'h00, 8'h07, 8'h01, 8'h02});
    timeout_pulse(1'b1, 8'h03);
    send_byte(8'h03);

    // Asynchronous reset in the middle of a pixel triple.
    send_seq('{8'h01, 8'h00, 8'h05, 8'h11});
    idle(1);
    mon_en = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    mon_en = 1'b1;

    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: begin
          case ($urandom_range(0, 3))
            0:       hi = 8'h00;
            1:       hi = 8'h01;
            2:       hi = 8'(2 + $urandom_range(0, 1));
            default: hi = 8'($urandom_range(0, 255));
          endcase
          send_byte(8'h01);
          send_byte(hi);
          send_byte(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 4) * 3 + $urandom_range(0, 2)) send_byte(8'($urandom_range(0, 255)));
          timeout_pulse(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        4: begin
          send_byte(8'h02);
          send_byte(8'($urandom_range(0, 6)));
          send_byte(8'($urandom_range(0, 255)));
        end
        5: send_byte(8'h03);
        6: send_byte(8'h04);
        7: begin
          cmd = 8'($urandom_range(5, 255));
          if ($urandom_range(0, 3) == 0) cmd = 8'h00;
          send_byte(cmd);
          repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 255)));
          timeout_pulse(1'b0, 8'h00);
        end
        8: ack_pulse();
        default: begin
          idle($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) timeout_pulse(1'b0, 8'h00);
        end
      endcase
    end
    send_byte(8'h03);
    idle(3);

    check("fb_pending", 64'(fbq.size()), 64'd0);
    check("tx_pending", 64'(txq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
